aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Sequential AES key-schedule engine for 128-, 192- and 256-bit keys, chosen per run by a key-length input. It expands the cipher key one 32-bit word per clock into an on-chip round-key store and signals completion. It then serves any round key through a combinational read port. The encryption datapath uses it in place of per-round combinational expansion; it instantiates four existing `Sub_byte` S-boxes.

## Interface
- `MAX_KEY_BITS`, default 256: largest key supported; legal values are 128, 192 and 256. The store depth is 4·(Nr_max+1) words, i.e. 44, 52 or 60.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request expansion; sampled only in IDLE.
- `key_len` in [0:1]: key length. 00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- `key_in` in [0:MAX_KEY_BITS-1]: cipher key, MSB-first. Word 0 is `key_in[0:31]`. Shorter keys occupy the low-numbered bits.
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle completion pulse.
- `keys_valid` out 1: store holds a complete schedule.
- `nr` out [0:3]: rounds for the latched key_len (10/12/14); 0 until the first accepted start.
- `rk_idx` in [0:3]: round-key index to read.
- `rk_out` out [0:127]: the four words w[4·rk_idx .. 4·rk_idx+3], combinational.

## Operation
- **Per-length constants:** Nk = 4/6/8, Nr = 10/12/14, total words T = 4·(Nr+1) = 44/52/60.
- **Byte order:** byte 0 of a word is bits [0:7].
  - RotWord([b0,b1,b2,b3]) = [b1,b2,b3,b0].
  - SubWord applies the S-box to each byte.
- **States:** IDLE, EXPAND, DONE.
- **IDLE:**
  - `start`=1 with a legal key_len (supported by `MAX_KEY_BITS`, not 11):
    - latch Nk and Nr;
    - write w[0..Nk-1] from key_in;
    - set i = Nk and rcon = 0x01;
    - clear `keys_valid`;
    - go to EXPAND.
  - An illegal or unsupported key_len: start ignored, no state change.
- **EXPAND:** each cycle computes w[i] from temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,00,00,00}, then rcon = xtime(rcon), i.e. left shift, XOR 0x1b on carry-out.
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] ^ temp, and i increments.
  - The i mod Nk term uses a counter that wraps at Nk, not a divider.
  - After writing w[T-1], go to DONE.
- **DONE:** one cycle. `done`=1 and `keys_valid` is set, then return to IDLE.
- **Start handling:** `start` in EXPAND or DONE is ignored and not queued.
- **Read port:**
  - `rk_out` is only guaranteed while `keys_valid`=1.
  - rk_idx > nr returns all zeros.
  - During `busy`, `rk_out` reflects the partially rewritten store; the store is not cleared on start.
- **Reset:**
  - IDLE; `busy`, `done`, `keys_valid` = 0; `nr` = 0; i and rcon cleared.
  - Store contents are don't-care, so `rk_out` is unspecified after reset.
  - Reset in any state, including mid-EXPAND, aborts the run with no `done`.

## Timing
- Start is sampled at edge E. EXPAND writes w[Nk] at E+1 and w[T-1] at E+(T-Nk).
- `busy` is high for cycles E+1 .. E+(T-Nk), i.e. 40/46/52 cycles.
- `done` and `keys_valid` rise in cycle E+(T-Nk)+1, i.e. 41/47/53 cycles after start; `busy` is low in that cycle.
- `done` and `keys_valid` are high together; `keys_valid` holds until the next accepted start or reset.
- The earliest next start is accepted at the edge ending the DONE cycle +1, so there are 2 idle-path cycles between runs.
- The `rk_out` path is combinational from `rk_idx` and the store, with no output register.
- The critical path is S-box + XOR tree for one word; only one word is produced per cycle.

## Test plan
- **AES-128 (FIPS-197 A.1):** key 2b7e1516 28aed2a6 abf71588 09cf4f3c, key_len 00.
  - `done` 41 cycles after start; nr = 10.
  - rk_idx 1 → a0fafe17 88542cb1 23a33939 2a6c7605.
  - rk_idx 10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- **AES-192 (A.2):** key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - `done` at 47 cycles; nr = 12.
  - w[6] = fe0c91f7; w[51] = 01002202.
- **AES-256 (A.3):** key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - `done` at 53 cycles.
  - w[8] = 9ba35411; w[12] = a8b09c1a (the SubWord-only branch); w[59] = 706c631e.
- **Back-to-back and ignored starts:** AES-256 run, then an AES-128 run.
  - The second run reproduces the A.1 values.
  - rk_idx 12 after the 128-bit run → 0.
  - `start` pulsed mid-EXPAND produces no extra `done`.
- **Reset mid-run:** `rst` 20 cycles into EXPAND.
  - Next cycle `busy` = `done` = `keys_valid` = 0; no `done` follows.
  - A fresh AES-128 run then yields the A.1 keys.
- **Illegal key_len:** key_len 11, or 10 with MAX_KEY_BITS = 128.
  - `busy` stays 0 and `keys_valid` is unchanged.

Source files
------------

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_expander
//  Purpose  : Sequential AES-128/192/256 key schedule. Produces one 32-bit
//             schedule word per clock into an on-chip store and serves any
//             round key through a combinational read port.
//  Revision : 1.0  initial release
// ============================================================================
module aes_key_expander #(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              key_len,
   input  logic [MAX_KEY_BITS-1:0] key_in,
   output logic                    busy,
   output logic                    done,
   output logic                    keys_valid,
   output logic [3:0]              nr,
   input  logic [3:0]              rk_idx,
   output logic [127:0]            rk_out
);

   localparam int NR_MAX    = (MAX_KEY_BITS == 256) ? 14 : (MAX_KEY_BITS == 192) ? 12 : 10;
   localparam int DEPTH     = 4 * (NR_MAX + 1);
   localparam int KEY_WORDS = MAX_KEY_BITS / 32;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXPAND = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [5:0]  i_q, i_d;         // index of the next word to produce
   logic [2:0]  cnt_q, cnt_d;     // i mod Nk, kept as a wrapping counter
   logic [7:0]  rcon_q, rcon_d;
   logic [5:0]  nk_q, nk_d;
   logic [3:0]  nr_q, nr_d;
   logic        kv_q, kv_d;
   logic [31:0] store_q [DEPTH];
   logic [31:0] store_d [DEPTH];

   logic        w_len_ok;
   logic [5:0]  w_nk_sel;
   logic [3:0]  w_nr_sel;
   logic [31:0] w_prev, w_back, w_rot, w_sbox_in, w_sub, w_temp, w_new;
   logic [5:0]  w_last_idx, w_base;
   logic [7:0]  w_xtime;

   // Decode the requested key length; lengths wider than the build are refused
   always_comb begin
      w_len_ok = 1'b0;
      w_nk_sel = 6'd4;
      w_nr_sel = 4'd10;
      case (key_len)
         2'b00: begin w_len_ok = 1'b1;                  w_nk_sel = 6'd4; w_nr_sel = 4'd10; end
         2'b01: begin w_len_ok = (MAX_KEY_BITS >= 192); w_nk_sel = 6'd6; w_nr_sel = 4'd12; end
         2'b10: begin w_len_ok = (MAX_KEY_BITS == 256); w_nk_sel = 6'd8; w_nr_sel = 4'd14; end
         default: w_len_ok = 1'b0;
      endcase
   end

   // One-word schedule datapath: temp from w[i-1], combined with w[i-Nk]
   assign w_prev     = store_q[i_q - 6'd1];
   assign w_back     = store_q[i_q - nk_q];
   assign w_rot      = {w_prev[23:0], w_prev[31:24]};
   assign w_sbox_in  = (cnt_q == 3'd0) ? w_rot : w_prev;
   assign w_xtime    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   assign w_last_idx = {nr_q, 2'b00} + 6'd3;

   generate
      for (genvar b = 0; b < 4; b++) begin : g_sbox
         Sub_byte u_sbox (
            .in_byte  (w_sbox_in[8*b +: 8]),
            .out_byte (w_sub[8*b +: 8])
         );
      end
   endgenerate

   // Select the temp transform for this word position
   always_comb begin
      w_temp = w_prev;
      if (cnt_q == 3'd0)
         w_temp = w_sub ^ {rcon_q, 24'h000000};
      else if (nk_q == 6'd8 && cnt_q == 3'd4)
         w_temp = w_sub;
   end

   assign w_new = w_back ^ w_temp;

   // Control FSM and store update
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      cnt_d   = cnt_q;
      rcon_d  = rcon_q;
      nk_d    = nk_q;
      nr_d    = nr_q;
      kv_d    = kv_q;
      store_d = store_q;
      case (state_q)
         S_IDLE: begin
            if (start && w_len_ok) begin
               nk_d    = w_nk_sel;
               nr_d    = w_nr_sel;
               i_d     = w_nk_sel;
               cnt_d   = 3'd0;
               rcon_d  = 8'h01;
               kv_d    = 1'b0;
               state_d = S_EXPAND;
               for (int k = 0; k < KEY_WORDS; k++) begin
                  if (6'(k) < w_nk_sel)
                     store_d[k] = key_in[MAX_KEY_BITS-1-32*k -: 32];
               end
            end
         end
         S_EXPAND: begin
            store_d[i_q] = w_new;
            i_d          = i_q + 6'd1;
            cnt_d        = (cnt_q == nk_q[2:0] - 3'd1) ? 3'd0 : cnt_q + 3'd1;
            if (cnt_q == 3'd0)
               rcon_d = w_xtime;
            if (i_q == w_last_idx) begin
               kv_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= 6'd0;
         cnt_q   <= 3'd0;
         rcon_q  <= 8'h00;
         nk_q    <= 6'd0;
         nr_q    <= 4'd0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         nk_q    <= nk_d;
         nr_q    <= nr_d;
         kv_q    <= kv_d;
      end
   end

   // Round-key store; contents are not reset
   always_ff @(posedge clk) begin
      store_q <= store_d;
   end

   // Combinational round-key read; indices beyond the latched Nr read as zero
   assign w_base = {rk_idx, 2'b00};
   always_comb begin
      rk_out = 128'd0;
      if (rk_idx <= nr_q)
         rk_out = {store_q[w_base], store_q[w_base + 6'd1],
                   store_q[w_base + 6'd2], store_q[w_base + 6'd3]};
   end

   assign busy       = (state_q == S_EXPAND);
   assign done       = (state_q == S_DONE);
   assign keys_valid = kv_q;
   assign nr         = nr_q;

endmodule

// ============================================================================
//  Module   : Sub_byte
//  Purpose  : AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
//  Revision : 1.0  initial release
// ============================================================================
module Sub_byte (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k])
            p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] w_sq, w_inv;

   // Inverse as x^(2+4+...+128) = x^254; zero maps to zero naturally
   always_comb begin
      w_sq  = in_byte;
      w_inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         w_sq  = gf_mul(w_sq, w_sq);
         w_inv = gf_mul(w_inv, w_sq);
      end
   end

   assign out_byte = w_inv
                   ^ {w_inv[6:0], w_inv[7]}
                   ^ {w_inv[5:0], w_inv[7:6]}
                   ^ {w_inv[4:0], w_inv[7:5]}
                   ^ {w_inv[3:0], w_inv[7:4]}
                   ^ 8'h63;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_key_expander
//  Purpose  : Scoreboard bench for aes_key_expander using FIPS-197 vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_key_expander;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] M_W0 = 128'hffffffff_00000000_00000000_00000000;
   localparam logic [127:0] M_W2 = 128'h00000000_00000000_ffffffff_00000000;
   localparam logic [127:0] M_W3 = 128'h00000000_00000000_00000000_ffffffff;
   localparam logic [127:0] M_ALL = {128{1'b1}};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   key_len = 2'b00;
   logic [255:0] key_in = '0;
   logic [3:0]   rk_idx = 4'd0;
   logic         busy, done, keys_valid;
   logic [3:0]   nr;
   logic [127:0] rk_out;

   logic         start1 = 1'b0;
   logic [1:0]   key_len1 = 2'b00;
   logic [3:0]   rk_idx1 = 4'd0;
   logic         busy1, done1, kv1;
   logic [3:0]   nr1;
   logic [127:0] rk_out1;

   aes_key_expander #(.MAX_KEY_BITS(256)) u_dut (
      .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
      .busy(busy), .done(done), .keys_valid(keys_valid), .nr(nr),
      .rk_idx(rk_idx), .rk_out(rk_out)
   );

   aes_key_expander #(.MAX_KEY_BITS(128)) u_dut128 (
      .clk(clk), .rst(rst), .start(start1), .key_len(key_len1), .key_in(K128[255:128]),
      .busy(busy1), .done(done1), .keys_valid(kv1), .nr(nr1),
      .rk_idx(rk_idx1), .rk_out(rk_out1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string      name;
      int         cyc;
      logic [3:0] nr;
   } done_t;

   typedef struct {
      string        name;
      int           kind;   // 0: status {busy,done,keys_valid,nr}, 1: rk_out read
      int           sel;    // 0: main instance, 1: 128-bit instance
      logic [127:0] exp;
      logic [127:0] mask;
   } chk_t;

   done_t done_q[$];
   chk_t  chk_q[$];
   logic  chk_req = 1'b0;
   int    n_cmp = 0;
   int    n_fail = 0;

   done_t        md;
   chk_t         mc;
   logic [127:0] act;

   // Monitor: pops expectations whenever the DUT finishes or a check is strobed
   always @(negedge clk) begin
      if (done) begin
         n_cmp = n_cmp + 1;
         if (done_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_done at cycle %0d: actual done=1 required done=0", cyc);
         end else begin
            md = done_q.pop_front();
            if (cyc != md.cyc || nr != md.nr || keys_valid !== 1'b1 || busy !== 1'b0) begin
               n_fail = n_fail + 1;
               $display("FAIL %s: actual cycle=%0d nr=%0d kv=%b busy=%b required cycle=%0d nr=%0d kv=1 busy=0",
                        md.name, cyc, nr, keys_valid, busy, md.cyc, md.nr);
            end
         end
      end
      if (chk_req) begin
         n_cmp = n_cmp + 1;
         if (chk_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL chk_queue_empty at cycle %0d", cyc);
         end else begin
            mc = chk_q.pop_front();
            if (mc.kind == 0)
               act = (mc.sel == 0) ? {121'd0, busy, done, keys_valid, nr}
                                   : {121'd0, busy1, done1, kv1, nr1};
            else
               act = (mc.sel == 0) ? rk_out : rk_out1;
            if ((act & mc.mask) !== (mc.exp & mc.mask)) begin
               n_fail = n_fail + 1;
               $display("FAIL %s: actual %h required %h", mc.name, act & mc.mask, mc.exp & mc.mask);
            end
         end
      end
   end

   // All tasks start and end one time unit after a rising edge
   task automatic push_chk(input string nm, input int kind, input int sel,
                           input logic [127:0] exp, input logic [127:0] mask);
      chk_t c;
      c.name = nm; c.kind = kind; c.sel = sel; c.exp = exp; c.mask = mask;
      chk_q.push_back(c);
      chk_req = 1'b1;
      @(posedge clk); #1;
      chk_req = 1'b0;
   endtask

   task automatic chk_status(input string nm, input int sel, input logic b, input logic d,
                             input logic kv, input logic [3:0] n);
      push_chk(nm, 0, sel, {121'd0, b, d, kv, n}, {121'd0, 7'h7f});
   endtask

   task automatic rd(input string nm, input logic [3:0] idx, input logic [127:0] exp,
                     input logic [127:0] mask);
      rk_idx = idx;
      push_chk(nm, 1, 0, exp, mask);
   endtask

   // Issue a start; done is seen in the cycle after edge E+(T-Nk)
   task automatic run(input string nm, input logic [1:0] len, input logic [255:0] key,
                      input int lat, input logic [3:0] exp_nr, input bit expect_done);
      done_t d;
      @(negedge clk);
      start = 1'b1; key_len = len; key_in = key;
      @(posedge clk); #1;
      start = 1'b0;
      if (expect_done) begin
         d.name = nm; d.cyc = cyc + lat; d.nr = exp_nr;
         done_q.push_back(d);
      end
      chk_status({nm, "_busy"}, 0, 1'b1, 1'b0, 1'b0, exp_nr);
   endtask

   task automatic wait_done(input int max_cyc);
      done_t d;
      for (int k = 0; k < max_cyc; k++) begin
         if (done_q.size() == 0) break;
         @(posedge clk); #1;
      end
      while (done_q.size() != 0) begin
         d = done_q.pop_front();
         n_cmp  = n_cmp + 1;
         n_fail = n_fail + 1;
         $display("FAIL %s_timeout: actual no done required done at cycle %0d", d.name, d.cyc);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_status("reset_state", 0, 1'b0, 1'b0, 1'b0, 4'd0);

      // Reserved key length is refused
      @(negedge clk); start = 1'b1; key_len = 2'b11; key_in = K128;
      @(posedge clk); #1; start = 1'b0;
      chk_status("illegal_len_idle", 0, 1'b0, 1'b0, 1'b0, 4'd0);

      // AES-128
      run("aes128_done", 2'b00, K128, 40, 4'd10, 1'b1);
      wait_done(60);
      rd("aes128_rk0",  4'd0,  K128[255:128], M_ALL);
      rd("aes128_rk1",  4'd1,  RK1_128, M_ALL);
      rd("aes128_rk10", 4'd10, RK10_128, M_ALL);
      rd("aes128_rk12_zero", 4'd12, 128'd0, M_ALL);

      // Reserved length with a valid schedule held
      @(negedge clk); start = 1'b1; key_len = 2'b11;
      @(posedge clk); #1; start = 1'b0;
      chk_status("illegal_len_kv_held", 0, 1'b0, 1'b0, 1'b1, 4'd10);
      rd("aes128_rk1_after_illegal", 4'd1, RK1_128, M_ALL);

      // AES-192
      run("aes192_done", 2'b01, K192, 46, 4'd12, 1'b1);
      wait_done(70);
      rd("aes192_w0",  4'd0,  {32'h8e73b0f7, 96'd0}, M_W0);
      rd("aes192_w6",  4'd1,  {64'd0, 32'hfe0c91f7, 32'd0}, M_W2);
      rd("aes192_w51", 4'd12, {96'd0, 32'h01002202}, M_W3);

      // AES-256 with a start pulse mid-expansion that must be ignored
      run("aes256_done", 2'b10, K256, 52, 4'd14, 1'b1);
      repeat (10) begin @(posedge clk); #1; end
      start = 1'b1; key_len = 2'b00; key_in = K128;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(70);
      rd("aes256_w8",  4'd2,  {32'h9ba35411, 96'd0}, M_W0);
      rd("aes256_w12", 4'd3,  {32'ha8b09c1a, 96'd0}, M_W0);
      rd("aes256_w59", 4'd14, {96'd0, 32'h706c631e}, M_W3);

      // Back-to-back: AES-256 then AES-128 at the earliest accepted start
      run("b2b_256_done", 2'b10, K256, 52, 4'd14, 1'b1);
      wait_done(70);
      run("b2b_128_done", 2'b00, K128, 40, 4'd10, 1'b1);
      wait_done(60);
      rd("b2b_rk1",  4'd1,  RK1_128, M_ALL);
      rd("b2b_rk10", 4'd10, RK10_128, M_ALL);
      rd("b2b_rk12_zero", 4'd12, 128'd0, M_ALL);

      // Reset 20 cycles into expansion aborts with no done
      run("abort_run", 2'b10, K256, 52, 4'd14, 1'b0);
      repeat (19) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_status("after_abort_reset", 0, 1'b0, 1'b0, 1'b0, 4'd0);
      repeat (60) begin @(posedge clk); #1; end
      run("fresh128_done", 2'b00, K128, 40, 4'd10, 1'b1);
      wait_done(60);
      rd("fresh128_rk1",  4'd1,  RK1_128, M_ALL);
      rd("fresh128_rk10", 4'd10, RK10_128, M_ALL);

      // 128-bit build refuses a 256-bit request, accepts a 128-bit one
      @(negedge clk); start1 = 1'b1; key_len1 = 2'b10;
      @(posedge clk); #1; start1 = 1'b0;
      push_chk("dut128_refuse_256", 0, 1, {121'd0, 3'b000, 4'd0}, {121'd0, 7'h7f});
      @(negedge clk); start1 = 1'b1; key_len1 = 2'b00;
      @(posedge clk); #1; start1 = 1'b0;
      push_chk("dut128_accept_128", 0, 1, {121'd0, 3'b100, 4'd10}, {121'd0, 7'h7f});
      repeat (45) begin @(posedge clk); #1; end
      rk_idx1 = 4'd10;
      push_chk("dut128_rk10", 1, 1, RK10_128, M_ALL);
      push_chk("dut128_kv", 0, 1, {121'd0, 3'b001, 4'd10}, {121'd0, 7'h7f});

      repeat (5) begin @(posedge clk); #1; end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
